nand_tree_pipe: RTL

- Parametrised, pipelined successor to the two-input NAND test circuit.
- Reduces WIDTH inputs through a balanced 2-input AND tree, with a register rank after every tree level, and applies a final selectable inversion (NAND or AND).
- Carries a valid/ready handshake. Serves as a sequential (DFF-bearing) equivalence-check target for the SAT flow and as a reusable reduction stage.

---
 rtl/nand_tree_pkg.sv | 26 ++
 rtl/nand_tree_pipe_if.sv | 23 ++
 rtl/nand_tree_level.sv | 43 ++++
 rtl/nand_tree_pipe.sv | 99 +++++++++
 4 files changed

// File: rtl/nand_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined AND/NAND tree.
// Used by nand_tree_level and nand_tree_pipe.
package nand_tree_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int level_nodes(input int width, input int level);
        int n;
        n = width;
        for (int i = 0; i < 8; i++) begin
            if (i < level) n = (n + 1) / 2;
        end
        return n;
    endfunction

endpackage

// File: rtl/nand_tree_pipe_if.sv
// Operand/result valid-ready bundle for nand_tree_pipe.
// slave = the tree, master = the operand source / result sink.
interface nand_tree_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_inv;
    logic             in_valid;
    logic             in_ready;
    logic             out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_inv, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_inv, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/nand_tree_level.sv
// One tree level: pairwise AND, odd trailing node passes through,
// then an enable-gated register rank carrying valid and inv alongside.
module nand_tree_level
    import nand_tree_pkg::*;
#(
    parameter int IN_N  = 2,
    parameter int OUT_N = (IN_N + 1) / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_N-1:0]  in_nodes,
    input  logic             in_v,
    input  logic             in_inv,
    output logic [OUT_N-1:0] out_nodes,
    output logic             out_v,
    output logic             out_inv
);

    logic [OUT_N-1:0] and_n;

    for (genvar i = 0; i < OUT_N; i++) begin : g_node
        if (2 * i + 1 < IN_N) begin : g_and
            assign and_n[i] = in_nodes[2*i] & in_nodes[2*i+1];
        end else begin : g_pass
            assign and_n[i] = in_nodes[2*i];
        end
    end

    // rank register: data loads regardless of valid so nothing goes X
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_nodes <= '0;
            out_v     <= 1'b0;
            out_inv   <= 1'b0;
        end else if (en) begin
            out_nodes <= and_n;
            out_v     <= in_v;
            out_inv   <= in_inv;
        end
    end

endmodule

// File: rtl/nand_tree_pipe.sv
// Pipelined WIDTH-input AND/NAND reduction, one register rank per level,
// global stall. Optional NAND_TREE_SELFCHECK_EN adds a sticky mismatch flag.
module nand_tree_pipe
    import nand_tree_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int LAT   = clog2_f(WIDTH)
) (
    input logic             clk,
    input logic             rst_n,
    nand_tree_pipe_if.slave io
`ifdef NAND_TREE_SELFCHECK_EN
    ,
    output logic            mismatch
`endif
);

    logic stall;
    logic en;
    logic acc;
    logic fin_d;
    logic fin_v;
    logic fin_inv;

    assign stall        = io.out_valid & ~io.out_ready;
    assign en           = ~stall;
    assign io.in_ready  = ~stall;
    assign acc          = io.in_valid & io.in_ready;
    assign io.out_valid = fin_v;
    assign io.out_data  = fin_d ^ fin_inv;

    for (genvar k = 0; k < LAT; k++) begin : g_lvl
        localparam int NI = level_nodes(WIDTH, k);
        localparam int NO = level_nodes(WIDTH, k + 1);

        logic [NI-1:0] d;
        logic          v;
        logic          inv;
        logic [NO-1:0] q;
        logic          qv;
        logic          qinv;

        if (k == 0) begin : g_src
            assign d   = io.in_data;
            assign v   = acc;
            assign inv = io.in_inv;
        end else begin : g_src
            assign d   = g_lvl[k-1].q;
            assign v   = g_lvl[k-1].qv;
            assign inv = g_lvl[k-1].qinv;
        end

        nand_tree_level #(
            .IN_N (NI),
            .OUT_N(NO)
        ) u_lvl (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .in_nodes (d),
            .in_v     (v),
            .in_inv   (inv),
            .out_nodes(q),
            .out_v    (qv),
            .out_inv  (qinv)
        );

        if (k == LAT - 1) begin : g_tail
            assign fin_d   = q[0];
            assign fin_v   = qv;
            assign fin_inv = qinv;
        end
    end

`ifdef NAND_TREE_SELFCHECK_EN
    logic           ref_in;
    logic [LAT-1:0] ref_sr;

    assign ref_in = io.in_inv ? ~&io.in_data : &io.in_data;

    // flat reference delayed under the same stall as the tree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_sr <= '0;
        end else if (en) begin
            ref_sr[0] <= ref_in;
            for (int i = 1; i < LAT; i++) ref_sr[i] <= ref_sr[i-1];
        end
    end

    // sticky compare of tree result against the reference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mismatch <= 1'b0;
        else        mismatch <= mismatch |
                                (io.out_valid & (io.out_data ^ ref_sr[LAT-1]));
    end
`endif

endmodule
